// File: rtl/pwm_duty_ctrl.sv
// pwm_duty_ctrl: button-driven PWM duty register with single-step press and hold-to-repeat.
// Define DUTY_WRAP_EN for modulo step arithmetic instead of saturation.
module pwm_duty_ctrl #(
    parameter int SYS_CLOCK_FREQ = 50_000_000,
    parameter int HOLD_NS        = 500_000_000,
    parameter int REPEAT_NS      = 50_000_000,
    parameter int DUTY_WIDTH     = 8,
    parameter int STEP           = 1,
    parameter int DUTY_INIT      = 0
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  up_in,
    input  logic                  dn_in,
    input  logic                  load_en,
    input  logic [DUTY_WIDTH-1:0] load_val,
    output logic [DUTY_WIDTH-1:0] duty_out,
    output logic                  duty_upd,
    output logic                  rpt_active
);
    localparam int NS_PER_CYC    = 1_000_000_000 / SYS_CLOCK_FREQ;
    localparam int HOLD_RAW      = HOLD_NS / NS_PER_CYC;
    localparam int REPEAT_RAW    = REPEAT_NS / NS_PER_CYC;
    localparam int HOLD_CYCLES   = HOLD_RAW < 1 ? 1 : HOLD_RAW;
    localparam int REPEAT_CYCLES = REPEAT_RAW < 1 ? 1 : REPEAT_RAW;
    localparam int MAX_CYCLES    = HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW            = $clog2(MAX_CYCLES) + 1;
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);
    localparam logic [DUTY_WIDTH:0] STEP_X = (DUTY_WIDTH + 1)'(STEP);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    state_t                r_state, w_next;
    logic [TW-1:0]         r_timer, w_timer;
    logic                  r_up_q, r_dn_q, r_up_p, r_dn_p;
    logic                  r_dir, w_dir, w_step;
    logic                  w_up_rise, w_dn_rise, w_abort;
    logic                  r_upd, r_rpt;
    logic [DUTY_WIDTH-1:0] r_duty, w_stepped, w_duty;

    assign w_up_rise = r_up_q & ~r_up_p;
    assign w_dn_rise = r_dn_q & ~r_dn_p;
    // Leaving a held state: the active button let go, or the opposite one pressed.
    assign w_abort = r_dir ? (~r_up_q | r_dn_q) : (~r_dn_q | r_up_q);

    always_comb begin
        w_next  = r_state;
        w_timer = r_timer + 1'b1;
        w_dir   = r_dir;
        w_step  = 1'b0;
        case (r_state)
            IDLE: begin
                w_timer = '0;
                if ((w_up_rise & ~r_dn_q) | (w_dn_rise & ~r_up_q)) begin
                    w_dir  = w_up_rise;
                    w_step = 1'b1;
                    w_next = HOLD;
                end
            end
            HOLD, REPEAT: begin
                if (w_abort) begin
                    w_next  = IDLE;
                    w_timer = '0;
                end else if (r_timer == (r_state == HOLD ? HOLD_LAST : REPEAT_LAST)) begin
                    w_step  = 1'b1;
                    w_timer = '0;
                    w_next  = REPEAT;
                end
            end
            default: begin
                w_next  = IDLE;
                w_timer = '0;
            end
        endcase
    end

`ifdef DUTY_WRAP_EN
    assign w_stepped = w_dir ? r_duty + STEP_X[DUTY_WIDTH-1:0] : r_duty - STEP_X[DUTY_WIDTH-1:0];
`else
    logic [DUTY_WIDTH:0] w_sum, w_diff;
    assign w_sum     = {1'b0, r_duty} + STEP_X;
    assign w_diff    = {1'b0, r_duty} - STEP_X;
    // Carry out saturates high; borrow out means duty < STEP and clamps to zero.
    assign w_stepped = w_dir ? (w_sum[DUTY_WIDTH] ? '1 : w_sum[DUTY_WIDTH-1:0])
                             : (w_diff[DUTY_WIDTH] ? '0 : w_diff[DUTY_WIDTH-1:0]);
`endif

    assign w_duty = load_en ? load_val : (w_step ? w_stepped : r_duty);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_dir   <= 1'b0;
            r_up_q  <= 1'b0;
            r_dn_q  <= 1'b0;
            r_up_p  <= 1'b0;
            r_dn_p  <= 1'b0;
            r_duty  <= DUTY_WIDTH'(DUTY_INIT);
            r_upd   <= 1'b0;
            r_rpt   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_timer <= w_timer;
            r_dir   <= w_dir;
            r_up_q  <= up_in;
            r_dn_q  <= dn_in;
            r_up_p  <= r_up_q;
            r_dn_p  <= r_dn_q;
            r_duty  <= w_duty;
            r_upd   <= w_duty != r_duty;
            r_rpt   <= w_next == REPEAT;
        end
    end

    assign duty_out   = r_duty;
    assign duty_upd   = r_upd;
    assign rpt_active = r_rpt;
endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// tb_pwm_duty_ctrl: table/scoreboard bench for pwm_duty_ctrl (HOLD=10, REPEAT=5 cycles, STEP=4, init 0x80).
module tb_pwm_duty_ctrl;
    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       up_in = 1'b0;
    logic       dn_in = 1'b0;
    logic       load_en = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] duty_out;
    logic       duty_upd;
    logic       rpt_active;

    typedef struct {
        logic       up;
        logic       dn;
        logic       ld;
        logic [7:0] lv;
        logic [7:0] ed;
        logic       eu;
        logic       er;
    } vec_t;

    vec_t  tbl[$];
    vec_t  sb[$];
    int    nvec = 0;
    int    nmis = 0;
    string tag = "init";

    always #5 clk = ~clk;

    pwm_duty_ctrl #(
        .SYS_CLOCK_FREQ(50_000_000),
        .HOLD_NS(200),
        .REPEAT_NS(100),
        .DUTY_WIDTH(8),
        .STEP(4),
        .DUTY_INIT(8'h80)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .up_in(up_in),
        .dn_in(dn_in),
        .load_en(load_en),
        .load_val(load_val),
        .duty_out(duty_out),
        .duty_upd(duty_upd),
        .rpt_active(rpt_active)
    );

    function automatic vec_t mk(input logic up, input logic dn, input logic ld, input logic [7:0] lv,
                                input logic [7:0] ed, input logic eu, input logic er);
        vec_t v;
        v.up = up; v.dn = dn; v.ld = ld; v.lv = lv; v.ed = ed; v.eu = eu; v.er = er;
        return v;
    endfunction

    task automatic cmp(input vec_t e);
        nvec++;
        if (duty_out !== e.ed || duty_upd !== e.eu || rpt_active !== e.er) begin
            nmis++;
            $display("FAIL %s vec %0d: got duty_out=%h duty_upd=%b rpt_active=%b, want duty_out=%h duty_upd=%b rpt_active=%b",
                     tag, nvec, duty_out, duty_upd, rpt_active, e.ed, e.eu, e.er);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        up_in = v.up; dn_in = v.dn; load_en = v.ld; load_val = v.lv;
        sb.push_back(v);
        @(posedge clk);
        #1;
        cmp(sb.pop_front());
    endtask

    task automatic add(input int n, input logic up, input logic dn, input logic ld, input logic [7:0] lv,
                       input logic [7:0] ed, input logic eu, input logic er);
        for (int i = 0; i < n; i++) tbl.push_back(mk(up, dn, ld, lv, ed, eu, er));
    endtask

    task automatic run_tbl(input string t);
        tag = t;
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
        tbl.delete();
    endtask

    task automatic do_rst();
        @(negedge clk);
        n_rst = 1'b0; up_in = 1'b0; dn_in = 1'b0; load_en = 1'b0;
        #2;
        tag = "reset";
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h80, 1'b0, 1'b0));
        cmp(sb.pop_front());
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, got %0d vectors, want completion", nvec);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w2, w3, w4;
        logic       u3;
        int         cnt;
        logic [7:0] d;
`ifdef DUTY_WRAP_EN
        w2 = 8'hFE; w3 = 8'hFA; w4 = 8'hF6; u3 = 1'b1;
`else
        w2 = 8'h00; w3 = 8'h00; w4 = 8'h00; u3 = 1'b0;
`endif
        do_rst();

        // single press: one step, back to idle, no further steps
        add(1, 1, 0, 0, 8'h00, 8'h80, 0, 0);
        add(1, 1, 0, 0, 8'h00, 8'h84, 1, 0);
        add(1, 1, 0, 0, 8'h00, 8'h84, 0, 0);
        add(14, 0, 0, 0, 8'h00, 8'h84, 0, 0);
        run_tbl("up_tap");

        // hold 30 cycles: steps at 1, 11, 16, 21, 26
        do_rst();
        tag = "up_hold";
        for (int e = 0; e < 36; e++) begin
            cnt = int'(e >= 1) + int'(e >= 11) + int'(e >= 16) + int'(e >= 21) + int'(e >= 26);
            d = 8'(8'h80 + 4 * cnt);
            apply(mk(e < 30, 1'b0, 1'b0, 8'h00, d,
                     e == 1 || e == 11 || e == 16 || e == 21 || e == 26, e >= 11 && e <= 30));
        end

        // load then hold down into the floor
        do_rst();
        add(1, 0, 0, 1, 8'h06, 8'h06, 1, 0);
        add(1, 0, 1, 0, 8'h00, 8'h06, 0, 0);
        add(1, 0, 1, 0, 8'h00, 8'h02, 1, 0);
        add(9, 0, 1, 0, 8'h00, 8'h02, 0, 0);
        add(1, 0, 1, 0, 8'h00, w2, 1, 1);
        add(4, 0, 1, 0, 8'h00, w2, 0, 1);
        add(1, 0, 1, 0, 8'h00, w3, u3, 1);
        add(4, 0, 1, 0, 8'h00, w3, 0, 1);
        add(1, 0, 1, 0, 8'h00, w4, u3, 1);
        add(1, 0, 0, 0, 8'h00, w4, 0, 1);
        add(6, 0, 0, 0, 8'h00, w4, 0, 0);
        run_tbl("dn_floor");

        // both buttons together, then opposite-button abort
        do_rst();
        add(3, 1, 1, 0, 8'h00, 8'h80, 0, 0);
        add(2, 0, 0, 0, 8'h00, 8'h80, 0, 0);
        add(1, 1, 0, 0, 8'h00, 8'h80, 0, 0);
        add(1, 1, 0, 0, 8'h00, 8'h84, 1, 0);
        add(3, 1, 0, 0, 8'h00, 8'h84, 0, 0);
        add(3, 1, 1, 0, 8'h00, 8'h84, 0, 0);
        add(12, 0, 1, 0, 8'h00, 8'h84, 0, 0);
        add(2, 0, 0, 0, 8'h00, 8'h84, 0, 0);
        add(1, 0, 1, 0, 8'h00, 8'h84, 0, 0);
        add(1, 0, 1, 0, 8'h00, 8'h80, 1, 0);
        add(4, 0, 0, 0, 8'h00, 8'h80, 0, 0);
        run_tbl("both_buttons");

        // load on the cycle a repeat step is due
        do_rst();
        tag = "load_vs_step";
        for (int e = 0; e < 25; e++) begin
            d = e < 1 ? 8'h80 : e < 11 ? 8'h84 : e < 16 ? 8'h88 : e < 21 ? 8'h10 : 8'h14;
            apply(mk(e <= 22, 1'b0, e == 16, 8'h10, d,
                     e == 1 || e == 11 || e == 16 || e == 21, e >= 11 && e <= 23));
        end

        // async reset mid-repeat, then quiet
        do_rst();
        tag = "rst_mid_repeat";
        for (int e = 0; e < 12; e++)
            apply(mk(1'b1, 1'b0, 1'b0, 8'h00, e < 1 ? 8'h80 : e < 11 ? 8'h84 : 8'h88,
                     e == 1 || e == 11, e >= 11));
        @(negedge clk);
        #2;
        n_rst = 1'b0; up_in = 1'b0;
        #1;
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h80, 1'b0, 1'b0));
        cmp(sb.pop_front());
        @(negedge clk);
        n_rst = 1'b1;
        add(15, 0, 0, 0, 8'h00, 8'h80, 0, 0);
        run_tbl("post_reset_idle");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
